// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: validates the start bit, steps an external 8-tick clocks_counter
// through data/parity/stop bits, and delivers each byte with parity and framing status.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tick,
    input  logic                  i_rx,
    input  logic                  i_par_en,
    input  logic                  i_par_odd,
    input  logic                  i_count_done,
    output logic                  o_count_enable,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sync_q;
    logic                    rx_s;
    logic                    rx_prev_q;
    logic [1:0]              half_cnt_q, half_cnt_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    par_en_q, par_en_d;
    logic                    par_odd_q, par_odd_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_err_q, par_err_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    out_par_err_q, out_par_err_d;
    logic                    frame_err_q, frame_err_d;
    logic                    active;
    logic                    sample;

    assign rx_s   = sync_q[1];
    assign active = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
    // Enable stays combinational so the counter wraps 7->0 on the same tick the FSM samples.
    assign sample = i_tick && i_count_done;

    assign o_count_enable = i_tick && active;
    assign o_busy         = (state_q != IDLE);
    assign o_data         = data_q;
    assign o_data_valid   = valid_q;
    assign o_par_err      = out_par_err_q;
    assign o_frame_err    = frame_err_q;

    always_comb begin
        state_d       = state_q;
        half_cnt_d    = half_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        par_en_d      = par_en_q;
        par_odd_d     = par_odd_q;
        shift_d       = shift_q;
        par_err_d     = par_err_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        out_par_err_d = out_par_err_q;
        frame_err_d   = frame_err_q;

        case (state_q)
            IDLE: begin
                if (i_tick && rx_prev_q && !rx_s) begin
                    state_d    = START;
                    half_cnt_d = 2'd0;
                    par_en_d   = i_par_en;
                    par_odd_d  = i_par_odd;
                    par_err_d  = 1'b0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (half_cnt_q == 2'd3) begin
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_cnt_d = 4'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        half_cnt_d = half_cnt_q + 2'd1;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    par_err_d = (^shift_q) ^ rx_s ^ par_odd_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    state_d       = IDLE;
                    valid_d       = 1'b1;
                    data_d        = shift_q;
                    out_par_err_d = par_en_q & par_err_q;
                    frame_err_d   = ~rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q       <= IDLE;
            sync_q        <= 2'b11;
            rx_prev_q     <= 1'b1;
            half_cnt_q    <= 2'd0;
            bit_cnt_q     <= 4'd0;
            par_en_q      <= 1'b0;
            par_odd_q     <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            out_par_err_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= {sync_q[0], i_rx};
            rx_prev_q     <= i_tick ? rx_s : rx_prev_q;
            half_cnt_q    <= half_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            par_en_q      <= par_en_d;
            par_odd_q     <= par_odd_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            out_par_err_q <= out_par_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Datapath accumulators are always overwritten before use, so they carry no reset.
    always_ff @(posedge i_clk) begin
        shift_q   <= shift_d;
        par_err_q <= par_err_d;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural clocks_counter and a frame scoreboard.
module tb_uart_rx_ctrl;

    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          p;
        logic          f;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_tick;
    logic          i_rx = 1'b1;
    logic          i_par_en = 1'b0;
    logic          i_par_odd = 1'b0;
    logic          i_count_done;
    logic          o_count_enable;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic          o_par_err;
    logic          o_frame_err;
    logic          o_busy;

    int errors = 0;
    int checks = 0;

    logic [1:0] div = 2'd0;
    logic [2:0] cc;

    int            en_cnt = 0;
    int            busy_cnt = 0;
    int            dbl_cnt = 0;
    int            obs_wr = 0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] obs_d [64];
    logic          obs_p [64];
    logic          obs_f [64];

    int   rd = 0;
    exp_t exp_q[$];

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_tick         (i_tick),
        .i_rx           (i_rx),
        .i_par_en       (i_par_en),
        .i_par_odd      (i_par_odd),
        .i_count_done   (i_count_done),
        .o_count_enable (o_count_enable),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .o_par_err      (o_par_err),
        .o_frame_err    (o_frame_err),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // One tick every 4 clocks.
    always @(posedge i_clk) div <= div + 2'd1;
    assign i_tick = (div == 2'd3);

    // Behavioural clocks_counter sharing the reset.
    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) cc <= 3'd0;
        else if (o_count_enable) cc <= cc + 3'd1;
    end
    assign i_count_done = (cc == 3'd7);

    always @(negedge i_clk) begin
        if (o_count_enable) en_cnt <= en_cnt + 1;
        if (o_busy) busy_cnt <= busy_cnt + 1;
        if (o_data_valid) begin
            if (obs_wr < 64) begin
                obs_d[obs_wr] <= o_data;
                obs_p[obs_wr] <= o_par_err;
                obs_f[obs_wr] <= o_frame_err;
            end
            obs_wr <= obs_wr + 1;
            if (prev_valid) dbl_cnt <= dbl_cnt + 1;
        end
        prev_valid <= o_data_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        i_rx = b;
        clks(32);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic pbit, input logic stop);
        i_par_en = pen;
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(stop);
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic p, input logic f);
        exp_t e;
        e.d = d;
        e.p = p;
        e.f = f;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd < obs_wr) begin
                check({tag, "_data"}, 32'(obs_d[rd]), 32'(e.d));
                check({tag, "_par_err"}, 32'(obs_p[rd]), 32'(e.p));
                check({tag, "_frame_err"}, 32'(obs_f[rd]), 32'(e.f));
                rd++;
            end else begin
                check({tag, "_missing_valid"}, 32'(obs_wr), 32'(rd + 1));
            end
        end
        check({tag, "_extra_valid"}, 32'(obs_wr), 32'(rd));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int b0;

        // Reset state
        i_rst = 1'b0;
        clks(10);
        check("rst_data", 32'(o_data), 32'h0);
        check("rst_valid", 32'(o_data_valid), 32'h0);
        check("rst_par_err", 32'(o_par_err), 32'h0);
        check("rst_frame_err", 32'(o_frame_err), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_count_enable", 32'(o_count_enable), 32'h0);
        i_rst = 1'b1;
        clks(40);

        // Nominal 0xA5, no parity
        e0 = en_cnt;
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        clks(64);
        drain("nominal");
        check("nominal_en_ticks", 32'(en_cnt - e0), 32'd72);

        // Even parity, good then bad; odd parity good
        i_par_odd = 1'b0;
        push_exp(8'h03, 1'b0, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        clks(64);
        push_exp(8'h03, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        clks(64);
        i_par_odd = 1'b1;
        e0 = en_cnt;
        push_exp(8'h03, 1'b0, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        clks(64);
        drain("parity");
        check("parity_en_ticks", 32'(en_cnt - e0), 32'd80);
        i_par_odd = 1'b0;

        // Framing error followed by a held-low break
        push_exp(8'h55, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        clks(96);
        b0 = busy_cnt;
        clks(96);
        check("break_busy_cycles", 32'(busy_cnt - b0), 32'd0);
        drain("framing");
        i_rx = 1'b1;
        clks(64);
        push_exp(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        clks(64);
        drain("after_break");

        // False start: 2-tick glitch
        b0 = busy_cnt;
        e0 = en_cnt;
        i_rx = 1'b0;
        clks(8);
        i_rx = 1'b1;
        clks(64);
        check("false_start_busy_cycles", 32'(busy_cnt - b0), 32'd16);
        check("false_start_en_ticks", 32'(en_cnt - e0), 32'd0);
        check("false_start_no_valid", 32'(obs_wr), 32'(rd));
        push_exp(8'h7E, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        clks(64);
        drain("after_false_start");

        // Reset during data bit 3
        i_par_en = 1'b0;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        i_rx = 1'b0;
        clks(16);
        check("pre_reset_busy", 32'(o_busy), 32'h1);
        i_rst = 1'b0;
        #1;
        check("midrst_data", 32'(o_data), 32'h0);
        check("midrst_valid", 32'(o_data_valid), 32'h0);
        check("midrst_par_err", 32'(o_par_err), 32'h0);
        check("midrst_frame_err", 32'(o_frame_err), 32'h0);
        check("midrst_busy", 32'(o_busy), 32'h0);
        check("midrst_count_enable", 32'(o_count_enable), 32'h0);
        clks(4);
        i_rx = 1'b1;
        i_rst = 1'b1;
        clks(64);
        check("midrst_no_valid", 32'(obs_wr), 32'(rd));
        push_exp(8'hC3, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        clks(64);
        drain("after_reset");

        // Back-to-back frames with no idle gap
        e0 = en_cnt;
        push_exp(8'h00, 1'b0, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        clks(64);
        drain("back_to_back");
        check("back_to_back_en_ticks", 32'(en_cnt - e0), 32'd144);

        check("valid_single_cycle", 32'(dbl_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
